spi_adc_reader: RTL and testbench
=================================

SPI_ADC_READER -- requirements
Module: spi_adc_reader

Interface
REQ-001 Parameter CLK_DIV, default 4: system-clock cycles per SCLK half-period (min 2).
REQ-002 Parameter FRAME_BITS, default 12: SCLK cycles per conversion frame.
REQ-003 Parameter LEAD_BITS, default 4: leading frame bits discarded before data.
REQ-004 Parameter DATA_BITS, default 8: result width; LEAD_BITS+DATA_BITS <= FRAME_BITS, elaboration error otherwise.
REQ-005 Parameter NUM_CH, default 2: number of ADCs, each with its own chip select; CH_W = max(1, clog2(NUM_CH)).
REQ-006 Parameter QUIET_CYC, default 2: CS_n-high gap after each frame (min 1).
REQ-007 One clock; reset is asynchronous and active-low: clock_50Mhz input 1 system clock; reset_n input 1 asynchronous active-low reset.
REQ-008 sample_req input 1: request one conversion on channel sample_ch.
REQ-009 sample_ch input CH_W: target channel, sampled with sample_req.
REQ-010 scan_en input 1: autonomous round-robin sampling mode.
REQ-011 clear_overrun input 1: clears overrun flag.
REQ-012 spi_sclk output 1: SPI clock, idles high.
REQ-013 spi_cs_n output NUM_CH: one-hot-low chip selects.
REQ-014 spi_sdo input NUM_CH: per-channel serial data, MSB first.
REQ-015 busy output 1: frame or quiet gap in progress.
REQ-016 sample_data output DATA_BITS: last completed result.
REQ-017 sample_ch_out output CH_W: channel of sample_data.
REQ-018 sample_valid output 1: one-cycle pulse, result updated.
REQ-019 overrun output 1: sticky, request dropped while busy.
REQ-020 bad_ch output 1: one-cycle pulse, request with sample_ch >= NUM_CH rejected.

Function
REQ-021 SCLK is generated from clock_50Mhz by a counter and driven from a register; no derived clock drives any flop.
REQ-022 States IDLE, SETUP, SHIFT, QUIET; IDLE->SETUP on accepted request; SETUP->SHIFT after CLK_DIV cycles; SHIFT->QUIET after FRAME_BITS bits; QUIET->IDLE after QUIET_CYC cycles.
REQ-023 Request accepted at edge k when state IDLE, sample_req=1, sample_ch<NUM_CH; busy=1 from cycle k+1 until return to IDLE.
REQ-024 SETUP and SHIFT: only the selected spi_cs_n bit low; all others high.
REQ-025 SHIFT bit: SCLK low CLK_DIV cycles then high CLK_DIV cycles; spi_sdo[ch] sampled on the final low-phase cycle (coincident with rising SCLK).
REQ-026 Frame bits 0..FRAME_BITS-1 in arrival order; sample_data = bits LEAD_BITS..LEAD_BITS+DATA_BITS-1, first arrival as MSB; other bits ignored.
REQ-027 sample_data, sample_ch_out update and sample_valid pulses in first QUIET cycle: cycle k+1+CLK_DIV+2*CLK_DIV*FRAME_BITS (k+101 at defaults); busy falls at k+103.
REQ-028 sample_data holds its value between frames.
REQ-029 sample_req while busy: dropped, overrun set next cycle; set wins over simultaneous clear_overrun.
REQ-030 sample_ch >= NUM_CH in IDLE: no frame, bad_ch pulses one cycle.
REQ-031 scan_en=1 in IDLE: self-issue next channel, counter wraps NUM_CH-1 -> 0; scan_en has priority over simultaneous sample_req, which is dropped without overrun.
REQ-032 scan_en deasserted mid-frame: current frame completes normally.

Reset
REQ-033 reset_n low, any state: immediately spi_cs_n all ones, spi_sclk=1, state IDLE, busy=0, sample_valid=0, overrun=0, bad_ch=0, sample_data=0, sample_ch_out=0, scan counter=0; partial frame discarded, no sample_valid after release.
REQ-034 First request accepted no earlier than the second clock edge after reset_n rises.

Structure
REQ-035 Package spi_adc_pkg holds the state enum and default parameter constants.
REQ-036 One sub-module spi_adc_tick: half-period counter producing a one-cycle tick every CLK_DIV cycles, restartable.

Verification
REQ-037 Defaults, req ch0, model returns 0000_1010_0101 -> sample_data=0xA5, sample_ch_out=0, valid at k+101, busy low k+103.
REQ-038 req ch1 during ch0 frame -> overrun=1, ch1 CS_n stays high; clear_overrun -> overrun=0.
REQ-039 NUM_CH=3, sample_ch=3 -> bad_ch pulse, no CS_n activity, busy stays 0.
REQ-040 scan_en held 4 frames, NUM_CH=3 -> channels 0,1,2,0, one valid per frame, distinct data correct.
REQ-041 reset_n low at SHIFT bit 6 -> CS_n all high, SCLK high same cycle; no valid after release; next frame correct.
REQ-042 CLK_DIV=2, FRAME_BITS=16, LEAD_BITS=2, DATA_BITS=12 -> 12-bit result correct, SCLK period 4 cycles.

Source files
------------

// File: rtl/spi_adc_pkg.sv
// spi_adc_pkg: shared state encoding, default parameters and helpers for the SPI ADC reader
package spi_adc_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;
  localparam int CLK_DIV_D    = 4;
  localparam int FRAME_BITS_D = 12;
  localparam int LEAD_BITS_D  = 4;
  localparam int DATA_BITS_D  = 8;
  localparam int NUM_CH_D     = 2;
  localparam int QUIET_CYC_D  = 2;
  function automatic int ch_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/spi_adc_if.sv
// spi_adc_if: SPI bus between the reader (master) and NUM_CH ADCs (slave side)
interface spi_adc_if #(parameter int NUM_CH = 2);
  logic              spi_sclk;
  logic [NUM_CH-1:0] spi_cs_n;
  logic [NUM_CH-1:0] spi_sdo;
  modport master (output spi_sclk, output spi_cs_n, input spi_sdo);
  modport slave (input spi_sclk, input spi_cs_n, output spi_sdo);
endinterface

// File: rtl/spi_adc_tick.sv
// spi_adc_tick: restartable divider giving a one-cycle tick every CLK_DIV clocks
module spi_adc_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clock_50Mhz,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLK_DIV - 1);
  // Count up to CLK_DIV-1 then wrap; restart holds the phase at zero
  always_ff @(posedge clock_50Mhz or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/spi_adc_reader.sv
// spi_adc_reader: multi-channel SPI ADC frame reader with single-shot and round-robin scan modes
module spi_adc_reader
  import spi_adc_pkg::*;
#(
  parameter int  CLK_DIV    = CLK_DIV_D,
  parameter int  FRAME_BITS = FRAME_BITS_D,
  parameter int  LEAD_BITS  = LEAD_BITS_D,
  parameter int  DATA_BITS  = DATA_BITS_D,
  parameter int  NUM_CH     = NUM_CH_D,
  parameter int  QUIET_CYC  = QUIET_CYC_D,
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic                 clock_50Mhz,
  input  logic                 reset_n,
  input  logic                 sample_req,
  input  logic [CH_W-1:0]      sample_ch,
  input  logic                 scan_en,
  input  logic                 clear_overrun,
  spi_adc_if.master            spi,
  output logic                 busy,
  output logic [DATA_BITS-1:0] sample_data,
  output logic [CH_W-1:0]      sample_ch_out,
  output logic                 sample_valid,
  output logic                 overrun,
  output logic                 bad_ch
);
  localparam int CNT_W = $clog2(FRAME_BITS > QUIET_CYC ? FRAME_BITS : QUIET_CYC);
  localparam logic [CH_W:0]    NCH      = (CH_W + 1)'(NUM_CH);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_Q   = CNT_W'(QUIET_CYC - 1);
  if (LEAD_BITS + DATA_BITS > FRAME_BITS) begin : g_bad_frame
    $error("LEAD_BITS + DATA_BITS must not exceed FRAME_BITS");
  end
  if (CLK_DIV < 2 || QUIET_CYC < 1 || FRAME_BITS < 2) begin : g_bad_timing
    $error("CLK_DIV >= 2, QUIET_CYC >= 1 and FRAME_BITS >= 2 required");
  end
  state_t                state, state_nxt;
  logic                  tick, rdy, hi, sclk_q, go, req_ok, bad_req, last_bit;
  logic [NUM_CH-1:0]     cs_q;
  logic [CNT_W-1:0]      cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [CH_W-1:0]       ch_q, scan_cnt, go_ch;
  spi_adc_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock_50Mhz(clock_50Mhz),
    .reset_n    (reset_n),
    .restart    (state == IDLE),
    .tick       (tick)
  );
  assign busy         = state != IDLE;
  assign spi.spi_sclk = sclk_q;
  assign spi.spi_cs_n = cs_q;
  // Request arbitration (scan beats single requests) and next-state selection
  always_comb begin
    req_ok    = {1'b0, sample_ch} < NCH;
    go        = state == IDLE && rdy && (scan_en || (sample_req && req_ok));
    go_ch     = scan_en ? scan_cnt : sample_ch;
    bad_req   = state == IDLE && rdy && !scan_en && sample_req && !req_ok;
    last_bit  = state == SHIFT && hi && tick && cnt == LAST_BIT;
    state_nxt = go ? SETUP :
                (state == SETUP && tick) ? SHIFT :
                last_bit ? QUIET :
                (state == QUIET && cnt == LAST_Q) ? IDLE : state;
  end
  // State register
  always_ff @(posedge clock_50Mhz or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  // Datapath: chip selects, SCLK phase, bit/quiet counter, shift register and result flags
  always_ff @(posedge clock_50Mhz or negedge reset_n)
    if (!reset_n) begin
      rdy           <= 1'b0;
      hi            <= 1'b0;
      sclk_q        <= 1'b1;
      cs_q          <= '1;
      cnt           <= '0;
      shreg         <= '0;
      ch_q          <= '0;
      scan_cnt      <= '0;
      sample_data   <= '0;
      sample_ch_out <= '0;
      sample_valid  <= 1'b0;
      overrun       <= 1'b0;
      bad_ch        <= 1'b0;
    end else begin
      rdy          <= 1'b1;
      sample_valid <= 1'b0;
      bad_ch       <= bad_req;
      overrun      <= (sample_req && state != IDLE) ? 1'b1 : clear_overrun ? 1'b0 : overrun;
      if (go) begin
        ch_q <= go_ch;
        cs_q <= ~(NUM_CH'(1) << go_ch);
        cnt  <= '0;
        hi   <= 1'b0;
        if (scan_en) scan_cnt <= scan_cnt == LAST_CH ? '0 : scan_cnt + 1'b1;
      end
      if (state == SETUP && tick) sclk_q <= 1'b0;
      if (state == SHIFT && tick) begin
        sclk_q <= !hi || last_bit;
        hi     <= !hi;
        if (!hi) shreg <= {shreg[FRAME_BITS-2:0], spi.spi_sdo[ch_q]};
        if (hi) cnt <= last_bit ? '0 : cnt + 1'b1;
        if (last_bit) begin
          cs_q          <= '1;
          sample_data   <= shreg[FRAME_BITS-1-LEAD_BITS -: DATA_BITS];
          sample_ch_out <= ch_q;
          sample_valid  <= 1'b1;
        end
      end
      if (state == QUIET) cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_spi_adc_reader.sv
// tb_spi_adc_reader: three reader configurations against a behavioural ADC and result model
module tb_spi_adc_reader;
  localparam int CD[3] = '{4, 4, 2};
  localparam int FR[3] = '{12, 12, 16};
  localparam int LD[3] = '{4, 4, 2};
  localparam int DB[3] = '{8, 8, 12};
  localparam int NC[3] = '{2, 3, 2};
  localparam int QC    = 2;
  typedef struct { int d; int c; logic [15:0] w; logic [15:0] e; } vec_t;
  logic clock_50Mhz = 1'b0;
  logic reset_n = 1'b0;
  logic clear_overrun = 1'b0;
  logic req [3];
  logic [1:0] ch_in [3];
  logic scan [3];
  logic [2:0] busy, valid, ovr, bad, sclk, sclk_prev;
  logic [7:0] d0, d1;
  logic [11:0] d2;
  logic c0, c2;
  logic [1:0] c1;
  logic [15:0] data [3];
  logic [1:0] cho [3];
  logic [2:0] cs [3];
  logic [2:0] sdo [3];
  logic [15:0] word [3][3];
  int rc [3][3];
  int total = 0;
  int bad_n = 0;
  vec_t tbl [6];
  always #5 clock_50Mhz = ~clock_50Mhz;
  spi_adc_if #(.NUM_CH(2)) if0 ();
  spi_adc_if #(.NUM_CH(3)) if1 ();
  spi_adc_if #(.NUM_CH(2)) if2 ();
  spi_adc_reader u0 (
    .clock_50Mhz(clock_50Mhz), .reset_n(reset_n), .sample_req(req[0]), .sample_ch(ch_in[0][0]),
    .scan_en(scan[0]), .clear_overrun(clear_overrun), .spi(if0), .busy(busy[0]), .sample_data(d0),
    .sample_ch_out(c0), .sample_valid(valid[0]), .overrun(ovr[0]), .bad_ch(bad[0]));
  spi_adc_reader #(.NUM_CH(3)) u1 (
    .clock_50Mhz(clock_50Mhz), .reset_n(reset_n), .sample_req(req[1]), .sample_ch(ch_in[1]),
    .scan_en(scan[1]), .clear_overrun(clear_overrun), .spi(if1), .busy(busy[1]), .sample_data(d1),
    .sample_ch_out(c1), .sample_valid(valid[1]), .overrun(ovr[1]), .bad_ch(bad[1]));
  spi_adc_reader #(.CLK_DIV(2), .FRAME_BITS(16), .LEAD_BITS(2), .DATA_BITS(12)) u2 (
    .clock_50Mhz(clock_50Mhz), .reset_n(reset_n), .sample_req(req[2]), .sample_ch(ch_in[2][0]),
    .scan_en(scan[2]), .clear_overrun(clear_overrun), .spi(if2), .busy(busy[2]), .sample_data(d2),
    .sample_ch_out(c2), .sample_valid(valid[2]), .overrun(ovr[2]), .bad_ch(bad[2]));
  assign data[0] = {8'h00, d0};
  assign data[1] = {8'h00, d1};
  assign data[2] = {4'h0, d2};
  assign cho[0] = {1'b0, c0};
  assign cho[1] = c1;
  assign cho[2] = {1'b0, c2};
  assign cs[0] = {1'b1, if0.spi_cs_n};
  assign cs[1] = if1.spi_cs_n;
  assign cs[2] = {1'b1, if2.spi_cs_n};
  assign sclk = {if2.spi_sclk, if1.spi_sclk, if0.spi_sclk};
  assign if0.spi_sdo = sdo[0][1:0];
  assign if1.spi_sdo = sdo[1];
  assign if2.spi_sdo = sdo[2][1:0];
  // ADC model: each selected ADC advances one frame bit per rising SCLK, MSB of its word first
  always @(negedge clock_50Mhz) begin
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 3; c++)
        if (cs[d][c]) rc[d][c] <= 0;
        else if (sclk[d] && !sclk_prev[d]) rc[d][c] <= rc[d][c] + 1;
      sclk_prev[d] <= sclk[d];
    end
  end
  always_comb begin
    for (int d = 0; d < 3; d++) begin
      sdo[d] = '0;
      for (int c = 0; c < 3; c++)
        sdo[d][c] = rc[d][c] < FR[d] ? word[d][c][FR[d]-1-rc[d][c]] : 1'b0;
    end
  end
  function automatic logic [15:0] model(input int d, input logic [15:0] w);
    logic [31:0] t;
    t = 32'(w) >> (FR[d] - LD[d] - DB[d]);
    return 16'(t & ((32'd1 << DB[d]) - 32'd1));
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic finish_frame(input int d, input int c, input logic [15:0] exp, input string nm);
    int n, r1, r2, vexp;
    logic pv;
    n = 1; r1 = 0; r2 = 0;
    vexp = 1 + CD[d] + 2 * CD[d] * FR[d];
    chk({nm, " busy_rise"}, busy[d], 1);
    chk({nm, " cs_sel"}, cs[d], 3'b111 ^ (3'b001 << c));
    pv = sclk[d];
    while (!valid[d] && n < 4000) begin
      @(negedge clock_50Mhz);
      n++;
      if (sclk[d] && !pv) begin
        if (r1 == 0) r1 = n;
        else if (r2 == 0) r2 = n;
      end
      pv = sclk[d];
    end
    chk({nm, " valid_cycle"}, n, vexp);
    chk({nm, " data"}, data[d], exp);
    chk({nm, " ch_out"}, cho[d], c);
    chk({nm, " first_rise"}, r1, 1 + 2 * CD[d]);
    chk({nm, " sclk_period"}, r2 - r1, 2 * CD[d]);
    @(negedge clock_50Mhz);
    n++;
    chk({nm, " valid_pulse"}, valid[d], 0);
    chk({nm, " cs_release"}, cs[d], 3'b111);
    while (busy[d] && n < 4000) begin
      @(negedge clock_50Mhz);
      n++;
    end
    chk({nm, " busy_fall"}, n, vexp + QC);
  endtask
  task automatic run_frame(input int d, input int c, input logic [15:0] w, input logic [15:0] exp, input string nm);
    word[d][c] = w;
    @(negedge clock_50Mhz);
    req[d] = 1'b1;
    ch_in[d] = 2'(c);
    @(negedge clock_50Mhz);
    req[d] = 1'b0;
    finish_frame(d, c, exp, nm);
  endtask
  task automatic wait_valid(input int d, output int n);
    n = 0;
    do begin
      @(negedge clock_50Mhz);
      n++;
    end while (!valid[d] && n < 400);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, required finish before 2000000");
    $fatal(1);
  end
  initial begin
    int n, d, c;
    logic [15:0] w;
    logic [1:0] sc_ch [4];
    logic [15:0] sc_dat [4];
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; ch_in[i] = '0; scan[i] = 1'b0;
      for (int j = 0; j < 3; j++) word[i][j] = '0;
    end
    tbl[0] = '{0, 0, 16'h00A5, 16'h00A5};
    tbl[1] = '{0, 1, 16'h0F3C, 16'h003C};
    tbl[2] = '{1, 2, 16'h05FF, 16'h00FF};
    tbl[3] = '{1, 0, 16'h0800, 16'h0000};
    tbl[4] = '{2, 1, 16'hB123, 16'h0C48};
    tbl[5] = '{2, 0, 16'h3FFC, 16'h0FFF};
    @(negedge clock_50Mhz);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d busy", i), busy[i], 0);
      chk($sformatf("rst%0d valid", i), valid[i], 0);
      chk($sformatf("rst%0d overrun", i), ovr[i], 0);
      chk($sformatf("rst%0d bad_ch", i), bad[i], 0);
      chk($sformatf("rst%0d data", i), data[i], 0);
      chk($sformatf("rst%0d ch_out", i), cho[i], 0);
      chk($sformatf("rst%0d sclk", i), sclk[i], 1);
      chk($sformatf("rst%0d cs", i), cs[i], 3'b111);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock_50Mhz);
    for (int i = 0; i < 6; i++)
      run_frame(tbl[i].d, tbl[i].c, tbl[i].w, tbl[i].e, $sformatf("tbl%0d", i));
    word[0][0] = 16'h00A5;
    @(negedge clock_50Mhz);
    req[0] = 1'b1; ch_in[0] = 2'd0;
    @(negedge clock_50Mhz);
    req[0] = 1'b0;
    repeat (10) @(negedge clock_50Mhz);
    req[0] = 1'b1; ch_in[0] = 2'd1;
    @(negedge clock_50Mhz);
    req[0] = 1'b0;
    chk("ovr set", ovr[0], 1);
    chk("ovr cs", cs[0], 3'b110);
    req[0] = 1'b1; clear_overrun = 1'b1;
    @(negedge clock_50Mhz);
    req[0] = 1'b0;
    chk("ovr set_beats_clear", ovr[0], 1);
    @(negedge clock_50Mhz);
    clear_overrun = 1'b0;
    chk("ovr cleared", ovr[0], 0);
    wait_valid(0, n);
    chk("ovr frame_valid", valid[0], 1);
    chk("ovr frame_data", data[0], 16'h00A5);
    chk("ovr frame_ch", cho[0], 0);
    repeat (3) @(negedge clock_50Mhz);
    chk("ovr idle", busy[0], 0);
    @(negedge clock_50Mhz);
    req[1] = 1'b1; ch_in[1] = 2'd3;
    @(negedge clock_50Mhz);
    req[1] = 1'b0;
    chk("badch pulse", bad[1], 1);
    chk("badch busy", busy[1], 0);
    chk("badch cs", cs[1], 3'b111);
    @(negedge clock_50Mhz);
    chk("badch pulse_end", bad[1], 0);
    chk("badch busy_after", busy[1], 0);
    chk("badch no_ovr", ovr[1], 0);
    word[1][0] = 16'h0A11; word[1][1] = 16'h0522; word[1][2] = 16'h0333;
    sc_ch = '{2'd0, 2'd1, 2'd2, 2'd0};
    sc_dat = '{16'h0011, 16'h0022, 16'h0033, 16'h00C4};
    @(negedge clock_50Mhz);
    scan[1] = 1'b1; req[1] = 1'b1; ch_in[1] = 2'd2;
    @(negedge clock_50Mhz);
    req[1] = 1'b0;
    chk("scan prio_cs", cs[1], 3'b110);
    chk("scan prio_no_ovr", ovr[1], 0);
    for (int f = 0; f < 4; f++) begin
      wait_valid(1, n);
      chk($sformatf("scan%0d valid", f), valid[1], 1);
      chk($sformatf("scan%0d ch", f), cho[1], sc_ch[f]);
      chk($sformatf("scan%0d data", f), data[1], sc_dat[f]);
      if (f == 0) word[1][0] = 16'h00C4;
      if (f == 2) begin
        repeat (10) @(negedge clock_50Mhz);
        chk("scan mid_frame_busy", busy[1], 1);
        scan[1] = 1'b0;
      end
    end
    n = 0;
    repeat (200) begin
      @(negedge clock_50Mhz);
      n += int'(valid[1]);
    end
    chk("scan stop_no_valid", n, 0);
    chk("scan stop_idle", busy[1], 0);
    word[0][1] = 16'h0F5A;
    @(negedge clock_50Mhz);
    req[0] = 1'b1; ch_in[0] = 2'd1;
    @(negedge clock_50Mhz);
    req[0] = 1'b0;
    repeat (54) @(negedge clock_50Mhz);
    chk("rst_mid sclk_low", sclk[0], 0);
    chk("rst_mid cs", cs[0], 3'b101);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async cs", cs[0], 3'b111);
    chk("rst_async sclk", sclk[0], 1);
    chk("rst_async busy", busy[0], 0);
    chk("rst_async data", data[0], 0);
    @(negedge clock_50Mhz);
    word[0][1] = 16'h00E7;
    req[0] = 1'b1; ch_in[0] = 2'd1;
    reset_n = 1'b1;
    @(negedge clock_50Mhz);
    chk("rst_rel first_edge_busy", busy[0], 0);
    chk("rst_rel valid", valid[0], 0);
    @(negedge clock_50Mhz);
    req[0] = 1'b0;
    finish_frame(0, 1, 16'h00E7, "rst_next");
    for (int i = 0; i < 9; i++) begin
      d = i % 3;
      c = int'($urandom_range(NC[d] - 1));
      w = 16'($urandom & ((32'd1 << FR[d]) - 32'd1));
      run_frame(d, c, w, model(d, w), $sformatf("rand%0d", i));
    end
    $display("test done: total=%0d bad=%0d", total, bad_n);
    $finish;
  end
endmodule
